// File: rtl/vpu_writeback.sv
// Write-back stage after the VPU: deskews the two output lanes in per-lane FIFOs and
// packs each aligned pair into one unified-buffer row write at sequential addresses.
module vpu_writeback #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] vpu_data_in_1,
   input  logic [DATA_W-1:0] vpu_data_in_2,
   input  logic              vpu_valid_in_1,
   input  logic              vpu_valid_in_2,
   input  logic              wb_start,
   input  logic [ADDR_W-1:0] wb_base_addr,
   input  logic [ADDR_W-1:0] wb_num_rows,
   input  logic              ub_wr_ready,
   output logic              ub_wr_en,
   output logic [ADDR_W-1:0] ub_wr_addr,
   output logic [DATA_W-1:0] ub_wr_data_1,
   output logic [DATA_W-1:0] ub_wr_data_2,
   output logic              wb_busy,
   output logic              wb_done,
   output logic              wb_overflow
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, num_rows_q, row_idx_q;

   logic [DATA_W-1:0] mem      [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [2];
   logic [PTR_W-1:0]  rd_ptr_q [2];
   logic [CNT_W-1:0]  cnt_q    [2];
   logic [DATA_W-1:0] lane_data [2];

   logic [1:0] lane_push, lane_full, lane_empty, lane_wr, lane_drop;
   logic       collecting, start_ok, flush, pop;

   assign collecting = (state_q == StCollect);
   assign start_ok   = (state_q == StIdle) && wb_start;
   // FIFOs are cleared both when a transfer starts and when DONE exits (discards residue)
   assign flush      = start_ok || (state_q == StDone);

   assign lane_data[0] = vpu_data_in_1;
   assign lane_data[1] = vpu_data_in_2;
   assign lane_push    = {vpu_valid_in_2, vpu_valid_in_1} & {2{collecting}};

   always_comb begin
      lane_full  = '0;
      lane_empty = '0;
      for (int k = 0; k < 2; k++) begin
         lane_full[k]  = (cnt_q[k] == CNT_W'(FIFO_DEPTH));
         lane_empty[k] = (cnt_q[k] == '0);
      end
   end

   // Both heads leave together; a lone sample waits for its partner
   assign pop = collecting && (lane_empty == 2'b00) && ub_wr_ready && (row_idx_q < num_rows_q);

   // A full FIFO still accepts a push when its head pops in the same cycle
   assign lane_wr   = lane_push & (~lane_full | {2{pop}});
   assign lane_drop = lane_push & lane_full & ~{2{pop}};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (wb_start) state_d = StCollect;
         StCollect: if (row_idx_q == num_rows_q) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (flush) begin
               wr_ptr_q[k] <= '0;
               rd_ptr_q[k] <= '0;
               cnt_q[k]    <= '0;
            end else begin
               if (lane_wr[k]) begin
                  mem[k][wr_ptr_q[k]] <= lane_data[k];
                  wr_ptr_q[k]         <= wr_ptr_q[k] + PTR_W'(1);
               end
               if (pop) rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
               cnt_q[k] <= cnt_q[k] + CNT_W'(lane_wr[k]) - CNT_W'(pop);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         base_q       <= '0;
         num_rows_q   <= '0;
         row_idx_q    <= '0;
         wb_overflow  <= 1'b0;
         ub_wr_en     <= 1'b0;
         ub_wr_addr   <= '0;
         ub_wr_data_1 <= '0;
         ub_wr_data_2 <= '0;
      end else begin
         state_q  <= state_d;
         ub_wr_en <= pop;
         if (pop) begin
            ub_wr_addr   <= base_q + row_idx_q;
            ub_wr_data_1 <= mem[0][rd_ptr_q[0]];
            ub_wr_data_2 <= mem[1][rd_ptr_q[1]];
            row_idx_q    <= row_idx_q + ADDR_W'(1);
         end
         if (start_ok) begin
            base_q      <= wb_base_addr;
            num_rows_q  <= wb_num_rows;
            row_idx_q   <= '0;
            wb_overflow <= 1'b0;
         end else if (lane_drop != 2'b00) begin
            wb_overflow <= 1'b1;
         end
      end
   end

   assign wb_busy = (state_q == StCollect);
   assign wb_done = (state_q == StDone);

endmodule

// File: tb/tb_vpu_writeback.sv
// Self-checking bench for vpu_writeback: directed scenarios plus randomized transfers,
// all run in lockstep against a queue-based transaction model.
module tb_vpu_writeback;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [DATA_W-1:0] d1 = '0, d2 = '0;
   logic              v1 = 1'b0, v2 = 1'b0;
   logic              wb_start = 1'b0;
   logic [ADDR_W-1:0] wb_base_addr = '0, wb_num_rows = '0;
   logic              ub_wr_ready = 1'b1;
   logic              ub_wr_en, wb_busy, wb_done, wb_overflow;
   logic [ADDR_W-1:0] ub_wr_addr;
   logic [DATA_W-1:0] ub_wr_data_1, ub_wr_data_2;

   always #5 clk = ~clk;

   vpu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .vpu_data_in_1(d1), .vpu_data_in_2(d2),
      .vpu_valid_in_1(v1), .vpu_valid_in_2(v2),
      .wb_start(wb_start), .wb_base_addr(wb_base_addr), .wb_num_rows(wb_num_rows),
      .ub_wr_ready(ub_wr_ready),
      .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
      .ub_wr_data_1(ub_wr_data_1), .ub_wr_data_2(ub_wr_data_2),
      .wb_busy(wb_busy), .wb_done(wb_done), .wb_overflow(wb_overflow)
   );

   int checks = 0, errors = 0, cyc = 0;

   // Transaction model: phase 0 idle, 1 collecting, 2 done
   int          m_phase = 0, m_issued = 0;
   logic [7:0]  m_base = '0, m_cnt = '0, m_addr = '0;
   logic [15:0] m_d1 = '0, m_d2 = '0;
   logic        m_en = 1'b0, m_ovf = 1'b0;
   logic [15:0] q1[$], q2[$];

   logic [39:0] dwr[$];
   int          dwr_cyc[$];
   int          done_cyc[$];
   int          cyc_bad = 0, bad_cyc = 0;
   logic [43:0] bad_dut, bad_ref;

   function automatic logic [43:0] dut_vec();
      return {ub_wr_en, ub_wr_addr, ub_wr_data_1, ub_wr_data_2, wb_busy, wb_done, wb_overflow};
   endfunction

   function automatic logic [43:0] ref_vec();
      return {m_en, m_addr, m_d1, m_d2, m_phase == 1, m_phase == 2, m_ovf};
   endfunction

   task automatic model_update();
      bit pop;
      if (rst) begin
         m_phase = 0; m_issued = 0; m_ovf = 0; m_en = 0;
         m_addr = '0; m_d1 = '0; m_d2 = '0;
         q1.delete(); q2.delete();
      end else begin
         m_en = 0;
         case (m_phase)
            0: if (wb_start) begin
               m_phase = 1; m_base = wb_base_addr; m_cnt = wb_num_rows;
               m_issued = 0; m_ovf = 0; q1.delete(); q2.delete();
            end
            1: begin
               pop = (q1.size() > 0) && (q2.size() > 0) && ub_wr_ready && (m_issued < int'(m_cnt));
               if (m_issued == int'(m_cnt)) m_phase = 2;
               if (pop) begin
                  m_en = 1; m_addr = m_base + 8'(m_issued);
                  m_d1 = q1.pop_front(); m_d2 = q2.pop_front();
                  m_issued++;
               end
               if (v1) begin if (q1.size() == DEPTH) m_ovf = 1; else q1.push_back(d1); end
               if (v2) begin if (q2.size() == DEPTH) m_ovf = 1; else q2.push_back(d2); end
            end
            default: begin m_phase = 0; q1.delete(); q2.delete(); end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      if (ub_wr_en === 1'b1) begin
         dwr.push_back({ub_wr_addr, ub_wr_data_1, ub_wr_data_2});
         dwr_cyc.push_back(cyc);
      end
      if (wb_done === 1'b1) done_cyc.push_back(cyc);
      if (dut_vec() !== ref_vec()) begin
         if (cyc_bad == 0) begin bad_cyc = cyc; bad_dut = dut_vec(); bad_ref = ref_vec(); end
         cyc_bad++;
      end
   endtask

   task automatic clear_logs();
      dwr.delete(); dwr_cyc.delete(); done_cyc.delete(); cyc_bad = 0;
   endtask

   task automatic quiet();
      v1 = 0; v2 = 0; wb_start = 0;
   endtask

   task automatic idle(input int n);
      quiet();
      repeat (n) tick();
   endtask

   task automatic start_xfer(input logic [7:0] b, input logic [7:0] n, output int sc);
      wb_start = 1; wb_base_addr = b; wb_num_rows = n; sc = cyc;
      tick();
      wb_start = 0;
   endtask

   task automatic push(input bit a, input logic [15:0] x1, input bit b, input logic [15:0] x2);
      v1 = a; d1 = x1; v2 = b; d2 = x2;
      tick();
   endtask

   task automatic test_reset();
      clear_logs();
      rst = 1; tick(); tick();
      checks++;
      if (dut_vec() !== 44'h0) begin
         errors++; $display("FAIL reset_values got %h want 0", dut_vec());
      end
      rst = 0; tick();
      checks++;
      if (dut_vec() !== 44'h0) begin
         errors++; $display("FAIL reset_idle got %h want 0", dut_vec());
      end
   endtask

   task automatic test_aligned();
      int sc; int pc[3];
      logic [39:0] exp;
      clear_logs(); ub_wr_ready = 1;
      start_xfer(8'h10, 8'd3, sc);
      for (int i = 0; i < 3; i++) begin
         pc[i] = cyc;
         push(1, 16'(2 * i + 1), 1, 16'(2 * i + 2));
      end
      idle(5);
      checks++;
      if (dwr.size() != 3) begin
         errors++; $display("FAIL aligned_count got %0d want 3", dwr.size());
      end
      for (int i = 0; i < dwr.size() && i < 3; i++) begin
         exp = {8'h10 + 8'(i), 16'(2 * i + 1), 16'(2 * i + 2)};
         checks++;
         if (dwr[i] !== exp || dwr_cyc[i] != pc[i] + 2) begin
            errors++;
            $display("FAIL aligned_row%0d got %h@%0d want %h@%0d", i, dwr[i], dwr_cyc[i], exp,
                     pc[i] + 2);
         end
      end
      checks++;
      if (done_cyc.size() != 1 || dwr_cyc.size() != 3 || done_cyc[0] != dwr_cyc[2] + 1) begin
         errors++; $display("FAIL aligned_done got %0d pulses want 1 after last write",
                            done_cyc.size());
      end
      checks++;
      if (wb_overflow !== 1'b0 || cyc_bad != 0) begin
         errors++; $display("FAIL aligned_lockstep ovf %b cycle %0d got %h want %h",
                            wb_overflow, bad_cyc, bad_dut, bad_ref);
      end
   endtask

   task automatic test_skew();
      int sc, l2c;
      logic [7:0] b;
      clear_logs(); ub_wr_ready = 1; b = 8'($urandom);
      start_xfer(b, 8'd2, sc);
      push(1, 16'd7, 0, 16'd0);
      push(1, 16'd8, 0, 16'd0);
      l2c = cyc;
      push(0, 16'd0, 1, 16'd9);
      push(0, 16'd0, 1, 16'd10);
      idle(5);
      checks++;
      if (dwr.size() != 2 || dwr[0] !== {b, 16'd7, 16'd9} || dwr[1] !== {b + 8'd1, 16'd8, 16'd10})
      begin
         errors++; $display("FAIL skew_rows got %0d rows first %h want %h", dwr.size(), dwr[0],
                            {b, 16'd7, 16'd9});
      end
      checks++;
      if (dwr_cyc.size() < 1 || dwr_cyc[0] != l2c + 2 || cyc_bad != 0) begin
         errors++; $display("FAIL skew_timing got %0d want %0d (lockstep bad %0d)",
                            dwr_cyc[0], l2c + 2, cyc_bad);
      end
   endtask

   task automatic test_overflow();
      int sc;
      logic [15:0] a[6], c[6];
      clear_logs(); ub_wr_ready = 0;
      start_xfer(8'h40, 8'd4, sc);
      for (int i = 0; i < 6; i++) begin
         a[i] = 16'($urandom); c[i] = 16'($urandom);
         push(1, a[i], 1, c[i]);
      end
      idle(2);
      checks++;
      if (wb_overflow !== 1'b1 || dwr.size() != 0) begin
         errors++; $display("FAIL ovf_flag got %b with %0d writes want 1 with 0",
                            wb_overflow, dwr.size());
      end
      ub_wr_ready = 1;
      idle(8);
      checks++;
      if (dwr.size() != 4) begin
         errors++; $display("FAIL ovf_count got %0d want 4", dwr.size());
      end
      for (int i = 0; i < dwr.size() && i < 4; i++) begin
         checks++;
         if (dwr[i] !== {8'h40 + 8'(i), a[i], c[i]}) begin
            errors++; $display("FAIL ovf_row%0d got %h want %h", i, dwr[i],
                               {8'h40 + 8'(i), a[i], c[i]});
         end
      end
      checks++;
      if (done_cyc.size() != 1 || cyc_bad != 0) begin
         errors++; $display("FAIL ovf_lockstep done %0d cycle %0d got %h want %h",
                            done_cyc.size(), bad_cyc, bad_dut, bad_ref);
      end
   endtask

   task automatic test_wrap();
      int sc;
      logic [7:0] exp_a[3];
      exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
      clear_logs(); ub_wr_ready = 1;
      start_xfer(8'hFE, 8'd3, sc);
      checks++;
      if (wb_overflow !== 1'b0 || wb_busy !== 1'b1) begin
         errors++; $display("FAIL wrap_start ovf %b busy %b want 0 1", wb_overflow, wb_busy);
      end
      for (int i = 0; i < 3; i++) push(1, 16'($urandom), 1, 16'($urandom));
      idle(5);
      checks++;
      if (dwr.size() != 3) begin
         errors++; $display("FAIL wrap_count got %0d want 3", dwr.size());
      end
      for (int i = 0; i < dwr.size() && i < 3; i++) begin
         checks++;
         if (dwr[i][39:32] !== exp_a[i]) begin
            errors++; $display("FAIL wrap_addr%0d got %h want %h", i, dwr[i][39:32], exp_a[i]);
         end
      end
      clear_logs();
      start_xfer(8'($urandom), 8'd0, sc);
      idle(5);
      checks++;
      if (dwr.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != sc + 2 || cyc_bad != 0) begin
         errors++; $display("FAIL zero_rows writes %0d done@%0d want 0 writes done@%0d",
                            dwr.size(), done_cyc[0], sc + 2);
      end
   endtask

   task automatic test_stray();
      int sc;
      logic [15:0] a[4], c[4];
      clear_logs(); ub_wr_ready = 1;
      for (int i = 0; i < 3; i++) push(1, 16'($urandom), 1, 16'($urandom));
      idle(3);
      checks++;
      if (dwr.size() != 0 || wb_overflow !== 1'b0 || wb_busy !== 1'b0) begin
         errors++; $display("FAIL stray_idle writes %0d ovf %b busy %b want 0 0 0",
                            dwr.size(), wb_overflow, wb_busy);
      end
      for (int i = 0; i < 4; i++) begin a[i] = 16'($urandom); c[i] = 16'($urandom); end
      start_xfer(8'h20, 8'd2, sc);
      wb_start = 1; wb_base_addr = 8'h80; wb_num_rows = 8'd5;
      push(1, a[0], 1, c[0]);
      wb_start = 0;
      for (int i = 1; i < 4; i++) push(1, a[i], 1, c[i]);
      idle(6);
      checks++;
      if (dwr.size() != 2 || done_cyc.size() != 1) begin
         errors++; $display("FAIL stray_count got %0d writes %0d done want 2 1",
                            dwr.size(), done_cyc.size());
      end
      for (int i = 0; i < dwr.size() && i < 2; i++) begin
         checks++;
         if (dwr[i] !== {8'h20 + 8'(i), a[i], c[i]}) begin
            errors++; $display("FAIL stray_row%0d got %h want %h", i, dwr[i],
                               {8'h20 + 8'(i), a[i], c[i]});
         end
      end
      checks++;
      if (cyc_bad != 0) begin
         errors++; $display("FAIL stray_lockstep cycle %0d got %h want %h", bad_cyc, bad_dut,
                            bad_ref);
      end
   endtask

   task automatic test_reset_mid();
      int sc;
      logic [7:0]  b;
      logic [15:0] a[4], c[4];
      clear_logs(); ub_wr_ready = 1;
      start_xfer(8'h33, 8'd4, sc);
      push(1, 16'h1111, 1, 16'h2222);
      push(1, 16'h3333, 1, 16'h4444);
      checks++;
      if (dwr.size() != 1) begin
         errors++; $display("FAIL rstmid_first got %0d writes want 1", dwr.size());
      end
      rst = 1;
      push(1, 16'h5555, 1, 16'h6666);
      checks++;
      if (dut_vec() !== 44'h0) begin
         errors++; $display("FAIL rstmid_zero got %h want 0", dut_vec());
      end
      rst = 0;
      idle(2);
      clear_logs(); b = 8'($urandom);
      start_xfer(b, 8'd4, sc);
      for (int i = 0; i < 4; i++) begin
         a[i] = 16'($urandom); c[i] = 16'($urandom);
         push(1, a[i], 1, c[i]);
      end
      idle(5);
      checks++;
      if (dwr.size() != 4 || done_cyc.size() != 1) begin
         errors++; $display("FAIL rstmid_count got %0d writes %0d done want 4 1",
                            dwr.size(), done_cyc.size());
      end
      for (int i = 0; i < dwr.size() && i < 4; i++) begin
         checks++;
         if (dwr[i] !== {b + 8'(i), a[i], c[i]}) begin
            errors++; $display("FAIL rstmid_row%0d got %h want %h", i, dwr[i],
                               {b + 8'(i), a[i], c[i]});
         end
      end
      checks++;
      if (cyc_bad != 0) begin
         errors++; $display("FAIL rstmid_lockstep cycle %0d got %h want %h", bad_cyc, bad_dut,
                            bad_ref);
      end
   endtask

   task automatic test_random();
      int sc, k;
      bit saw;
      logic [7:0] b, n;
      for (int t = 0; t < 20; t++) begin
         clear_logs();
         b = 8'($urandom); n = 8'($urandom_range(1, 8));
         ub_wr_ready = 1;
         start_xfer(b, n, sc);
         saw = 0; k = 0;
         while (k < 300 && !(saw && m_phase == 0)) begin
            v1 = 1'($urandom_range(0, 1)); d1 = 16'($urandom);
            v2 = 1'($urandom_range(0, 1)); d2 = 16'($urandom);
            ub_wr_ready = ($urandom_range(0, 3) != 0);
            wb_start = ($urandom_range(0, 15) == 0);
            wb_base_addr = 8'($urandom); wb_num_rows = 8'($urandom);
            tick();
            if (m_phase == 2) saw = 1;
            k++;
         end
         quiet(); ub_wr_ready = 1;
         checks++;
         if (k >= 300 || dwr.size() != int'(n) || done_cyc.size() != 1) begin
            errors++; $display("FAIL rand%0d_rows got %0d writes %0d done want %0d 1",
                               t, dwr.size(), done_cyc.size(), n);
         end
         for (int i = 0; i < dwr.size(); i++) begin
            checks++;
            if (dwr[i][39:32] !== b + 8'(i)) begin
               errors++; $display("FAIL rand%0d_addr%0d got %h want %h", t, i, dwr[i][39:32],
                                  b + 8'(i));
            end
         end
         checks++;
         if (cyc_bad != 0) begin
            errors++; $display("FAIL rand%0d_lockstep cycle %0d got %h want %h", t, bad_cyc,
                               bad_dut, bad_ref);
         end
         idle(2);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_skew();
      test_overflow();
      test_wrap();
      test_stray();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
